// File: rtl/dec_mac_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dec_mac_arbiter_pkg
// Purpose  : Shared widths and sym4 decomposition coefficients for the
//            wavelet decompose levels and the shared MAC arbiter.
// Contents : DEC_INTERNAL_WIDTH / DEC_COEF_WIDTH / DEC_COEF_FRAC,
//            pack_coefs() helper, SYM4_DEC_LO / SYM4_DEC_HI packed constants.
// Revision : 1.0 - initial release
// ============================================================================
package dec_mac_arbiter_pkg;

  localparam int DEC_INTERNAL_WIDTH = 48;  // Q25.23 samples
  localparam int DEC_COEF_WIDTH     = 25;
  localparam int DEC_COEF_FRAC      = 23;

  // Packs eight signed integer coefficients, tap k at [k*W +: W].
  function automatic logic [8*DEC_COEF_WIDTH-1:0] pack_coefs(
    input int c0, input int c1, input int c2, input int c3,
    input int c4, input int c5, input int c6, input int c7
  );
    int c [8];
    logic [8*DEC_COEF_WIDTH-1:0] p;
    c[0] = c0; c[1] = c1; c[2] = c2; c[3] = c3;
    c[4] = c4; c[5] = c5; c[6] = c6; c[7] = c7;
    p = '0;
    for (int k = 0; k < 8; k++) begin
      p[k*DEC_COEF_WIDTH +: DEC_COEF_WIDTH] = c[k][DEC_COEF_WIDTH-1:0];
    end
    return p;
  endfunction

  // sym4 analysis filters scaled by 2^23 and rounded to nearest.
  localparam logic [8*DEC_COEF_WIDTH-1:0] SYM4_DEC_LO = pack_coefs(
    -635569, -248601, 4174328, 6742249, 2498612, -832314, -105730, 270307);
  localparam logic [8*DEC_COEF_WIDTH-1:0] SYM4_DEC_HI = pack_coefs(
    -270307, -105730, 832314, 2498612, -6742249, 4174328, 248601, -635569);

endpackage
`default_nettype wire

// File: rtl/dec_mac_arbiter_mac8.sv
`default_nettype none
// ============================================================================
// Module   : dec_mac8
// Purpose  : 8-tap multiply / accumulate / truncate pipeline, 3 registered
//            stages, with a valid+id tag travelling alongside the data.
// Ports    : clk, rst          - clock, synchronous active-high reset
//            in_valid/in_id    - window strobe and requester tag
//            in_hi             - 1 selects DEC_HI, 0 selects DEC_LO
//            in_win            - 8 taps, tap k at [k*INTERNAL_WIDTH +: ...]
//            out_valid/out_id  - result strobe and tag (3 cycles later)
//            out_data          - truncated Q25.23 result, held when idle
//            busy              - any stage holds a valid window
// Revision : 1.0 - initial release
// ============================================================================
module dec_mac8 import dec_mac_arbiter_pkg::*; #(
  parameter int INTERNAL_WIDTH = DEC_INTERNAL_WIDTH,
  parameter int COEF_WIDTH     = DEC_COEF_WIDTH,
  parameter int COEF_FRAC      = DEC_COEF_FRAC,
  parameter logic [8*COEF_WIDTH-1:0] DEC_LO = '0,
  parameter logic [8*COEF_WIDTH-1:0] DEC_HI = '0,
  parameter int ID_WIDTH       = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  logic [ID_WIDTH-1:0]         in_id,
  input  logic                        in_hi,
  input  logic [8*INTERNAL_WIDTH-1:0] in_win,
  output logic                        out_valid,
  output logic [ID_WIDTH-1:0]         out_id,
  output logic [INTERNAL_WIDTH-1:0]   out_data,
  output logic                        busy
);

  localparam int PW = INTERNAL_WIDTH + COEF_WIDTH;      // product width
  localparam int SW = INTERNAL_WIDTH + COEF_WIDTH + 3;  // sum of 8 products

  logic signed [INTERNAL_WIDTH-1:0] tap_w  [8];
  logic signed [COEF_WIDTH-1:0]     coef_w [8];

  logic signed [PW-1:0]       prod_d [8];
  logic signed [PW-1:0]       prod_q [8];
  logic signed [SW-1:0]       sum_d, sum_q;
  logic [INTERNAL_WIDTH-1:0]  data_d, data_q;
  logic [2:0]                 vld_d, vld_q;
  logic [2:0][ID_WIDTH-1:0]   id_d, id_q;
  logic                       sum_unused;

  for (genvar k = 0; k < 8; k++) begin : g_tap
    assign tap_w[k]  = in_win[k*INTERNAL_WIDTH +: INTERNAL_WIDTH];
    assign coef_w[k] = in_hi ? DEC_HI[k*COEF_WIDTH +: COEF_WIDTH]
                             : DEC_LO[k*COEF_WIDTH +: COEF_WIDTH];
  end

  always_comb begin
    // Data stages only move when their tag is valid, so the output
    // register naturally holds its last result between strobes.
    for (int k = 0; k < 8; k++) begin
      prod_d[k] = in_valid ? PW'(tap_w[k]) * PW'(coef_w[k]) : prod_q[k];
    end
    sum_d = sum_q;
    if (vld_q[0]) begin
      sum_d = '0;
      for (int k = 0; k < 8; k++) begin
        sum_d = sum_d + SW'(prod_q[k]);
      end
    end
    data_d = vld_q[1] ? sum_q[COEF_FRAC+INTERNAL_WIDTH-1:COEF_FRAC] : data_q;
    vld_d  = {vld_q[1:0], in_valid};
    id_d   = {id_q[1:0], in_id};
    if (!vld_q[1]) id_d[2] = id_q[2];
  end

  // Integer headroom and fraction bits below the result are dropped.
  assign sum_unused = ^{sum_q[SW-1:COEF_FRAC+INTERNAL_WIDTH], sum_q[COEF_FRAC-1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 8; k++) prod_q[k] <= '0;
      sum_q  <= '0;
      data_q <= '0;
      vld_q  <= '0;
      id_q   <= '0;
    end else begin
      for (int k = 0; k < 8; k++) prod_q[k] <= prod_d[k];
      sum_q  <= sum_d;
      data_q <= data_d;
      vld_q  <= vld_d;
      id_q   <= id_d;
    end
  end

  assign out_valid = vld_q[2];
  assign out_id    = id_q[2];
  assign out_data  = data_q;
  assign busy      = |vld_q;

endmodule
`default_nettype wire

// File: rtl/dec_mac_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dec_mac_arbiter
// Purpose  : Round-robin arbiter sharing one dec_mac8 engine among NUM_REQ
//            decomposition-level requesters; one window granted per cycle.
// Ports    : clk, rst              - clock, synchronous active-high reset
//            req_valid/req_ready   - per-requester handshake (ready is comb.)
//            req_win/req_hi        - per-requester window and filter select
//            req_mask              - per-requester enable
//            rsp_valid/id/data     - result strobe, requester tag, result
//            busy                  - any window in flight
//            grant_cnt             - saturating per-requester grant counters
// Revision : 1.0 - initial release
// ============================================================================
module dec_mac_arbiter import dec_mac_arbiter_pkg::*; #(
  parameter int NUM_REQ        = 4,
  parameter int INTERNAL_WIDTH = DEC_INTERNAL_WIDTH,
  parameter int COEF_WIDTH     = DEC_COEF_WIDTH,
  parameter int COEF_FRAC      = DEC_COEF_FRAC,
  parameter logic [8*COEF_WIDTH-1:0] DEC_LO = '0,
  parameter logic [8*COEF_WIDTH-1:0] DEC_HI = '0,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_REQ-1:0]                  req_valid,
  output logic [NUM_REQ-1:0]                  req_ready,
  input  logic [NUM_REQ*8*INTERNAL_WIDTH-1:0] req_win,
  input  logic [NUM_REQ-1:0]                  req_hi,
  input  logic [NUM_REQ-1:0]                  req_mask,
  output logic                                rsp_valid,
  output logic [$clog2(NUM_REQ)-1:0]          rsp_id,
  output logic [INTERNAL_WIDTH-1:0]           rsp_data,
  output logic                                busy,
  output logic [NUM_REQ*CNT_WIDTH-1:0]        grant_cnt
);

  localparam int ID_WIDTH = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]                 elig_w, grant_w;
  logic                               grant_any_w;
  logic [ID_WIDTH-1:0]                grant_idx_w;
  logic [ID_WIDTH:0]                  cand_w;
  logic [8*INTERNAL_WIDTH-1:0]        win_w;
  logic                               hi_w;
  logic [ID_WIDTH-1:0]                rr_ptr_d, rr_ptr_q;
  logic [NUM_REQ-1:0][CNT_WIDTH-1:0]  cnt_d, cnt_q;

  // First eligible index at or above rr_ptr, wrapping. cand_w carries one
  // extra bit so the wrap works for non-power-of-two NUM_REQ.
  always_comb begin
    elig_w      = req_valid & req_mask & {NUM_REQ{~rst}};
    grant_w     = '0;
    grant_any_w = 1'b0;
    grant_idx_w = '0;
    cand_w      = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      cand_w = {1'b0, rr_ptr_q} + (ID_WIDTH+1)'(off);
      if (cand_w >= (ID_WIDTH+1)'(NUM_REQ)) cand_w = cand_w - (ID_WIDTH+1)'(NUM_REQ);
      if (!grant_any_w && elig_w[cand_w[ID_WIDTH-1:0]]) begin
        grant_any_w = 1'b1;
        grant_idx_w = cand_w[ID_WIDTH-1:0];
        grant_w[cand_w[ID_WIDTH-1:0]] = 1'b1;
      end
    end
  end

  always_comb begin
    win_w = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_w[i]) win_w = req_win[i*8*INTERNAL_WIDTH +: 8*INTERNAL_WIDTH];
    end
    hi_w = |(req_hi & grant_w);

    rr_ptr_d = rr_ptr_q;
    if (grant_any_w) begin
      rr_ptr_d = (grant_idx_w == ID_WIDTH'(NUM_REQ-1)) ? '0
                                                        : grant_idx_w + ID_WIDTH'(1);
    end

    cnt_d = cnt_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_w[i] && !(&cnt_q[i])) cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign req_ready = grant_w;
  assign grant_cnt = cnt_q;

  dec_mac8 #(
    .INTERNAL_WIDTH (INTERNAL_WIDTH),
    .COEF_WIDTH     (COEF_WIDTH),
    .COEF_FRAC      (COEF_FRAC),
    .DEC_LO         (DEC_LO),
    .DEC_HI         (DEC_HI),
    .ID_WIDTH       (ID_WIDTH)
  ) u_mac (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (grant_any_w),
    .in_id     (grant_idx_w),
    .in_hi     (hi_w),
    .in_win    (win_w),
    .out_valid (rsp_valid),
    .out_id    (rsp_id),
    .out_data  (rsp_data),
    .busy      (busy)
  );

endmodule
`default_nettype wire

// File: tb/tb_dec_mac_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dec_mac_arbiter
// Purpose  : Directed self-checking bench for dec_mac_arbiter: reset state,
//            lowpass/highpass single transfers, round-robin rotation, masking,
//            reset while in flight, counter saturation, truncation of
//            full-scale negative windows (second instance, NUM_REQ=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_dec_mac_arbiter;

  localparam int W = 48;
  localparam int C = 25;

  // Instance A: lowpass tap0 = 1.0, highpass tap7 = -1.0
  localparam logic [8*C-1:0] LO_A = {175'b0, 25'h0800000};
  localparam logic [8*C-1:0] HI_A = {25'h1800000, 175'b0};
  // Instance B: lowpass tap0 = 1-2^-23; highpass tap0 = 1-2^-23, tap1 = -3*2^-23
  localparam logic [8*C-1:0] LO_B = {175'b0, 25'h07FFFFF};
  localparam logic [8*C-1:0] HI_B = {150'b0, 25'h1FFFFFD, 25'h07FFFFF};

  logic clk = 1'b0;
  logic rst;

  logic [3:0]       req_valid_a, req_ready_a, req_hi_a, req_mask_a;
  logic [4*8*W-1:0] req_win_a;
  logic             rsp_valid_a, busy_a;
  logic [1:0]       rsp_id_a;
  logic [W-1:0]     rsp_data_a;
  logic [4*4-1:0]   grant_cnt_a;

  logic [1:0]       req_valid_b, req_ready_b, req_hi_b, req_mask_b;
  logic [2*8*W-1:0] req_win_b;
  logic             rsp_valid_b, busy_b;
  logic [0:0]       rsp_id_b;
  logic [W-1:0]     rsp_data_b;
  logic [2*16-1:0]  grant_cnt_b;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  dec_mac_arbiter #(
    .NUM_REQ(4), .DEC_LO(LO_A), .DEC_HI(HI_A), .CNT_WIDTH(4)
  ) dut_a (
    .clk(clk), .rst(rst),
    .req_valid(req_valid_a), .req_ready(req_ready_a), .req_win(req_win_a),
    .req_hi(req_hi_a), .req_mask(req_mask_a),
    .rsp_valid(rsp_valid_a), .rsp_id(rsp_id_a), .rsp_data(rsp_data_a),
    .busy(busy_a), .grant_cnt(grant_cnt_a)
  );

  dec_mac_arbiter #(
    .NUM_REQ(2), .DEC_LO(LO_B), .DEC_HI(HI_B)
  ) dut_b (
    .clk(clk), .rst(rst),
    .req_valid(req_valid_b), .req_ready(req_ready_b), .req_win(req_win_b),
    .req_hi(req_hi_b), .req_mask(req_mask_b),
    .rsp_valid(rsp_valid_b), .rsp_id(rsp_id_b), .rsp_data(rsp_data_b),
    .busy(busy_b), .grant_cnt(grant_cnt_b)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Single transfer from requester r of instance A; result expected 3 cycles on.
  task automatic xfer_a(input int r, input logic hi, input logic [W-1:0] exp);
    req_hi_a    = '0;
    req_hi_a[r] = hi;
    req_valid_a = 4'b0001 << r;
    @(negedge clk);
    check("a_ready", {60'b0, req_ready_a}, 64'(4'b0001 << r));
    tick();
    req_valid_a = '0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c == 1) check("a_busy", {63'b0, busy_a}, 64'd1);
      check("a_rsp_valid", {63'b0, rsp_valid_a}, (c == 3) ? 64'd1 : 64'd0);
      if (c >= 3) begin
        check("a_rsp_data", {16'b0, rsp_data_a}, {16'b0, exp});
        check("a_rsp_id", {62'b0, rsp_id_a}, 64'(r));
      end
      tick();
    end
  endtask

  task automatic xfer_b(input logic hi, input logic [W-1:0] exp);
    req_hi_b    = {hi, 1'b0};
    req_valid_b = 2'b10;
    @(negedge clk);
    check("b_ready", {62'b0, req_ready_b}, 64'd2);
    tick();
    req_valid_b = '0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      if (c == 3) begin
        check("b_rsp_valid", {63'b0, rsp_valid_b}, 64'd1);
        check("b_rsp_id", {63'b0, rsp_id_b}, 64'd1);
        check("b_rsp_data", {16'b0, rsp_data_b}, {16'b0, exp});
        check("b_sign", {63'b0, rsp_data_b[W-1]}, 64'd1);
      end
      tick();
    end
  endtask

  int seq_mask [6] = '{0, 1, 3, 0, 1, 3};

  initial begin
    rst = 1'b1;
    req_valid_a = 4'hF; req_mask_a = 4'hF; req_hi_a = '0; req_win_a = '0;
    req_valid_b = 2'b11; req_mask_b = 2'b11; req_hi_b = '0; req_win_b = '0;

    // Reset state; requests are all valid but ready must stay low.
    tick(); tick();
    @(negedge clk);
    check("rst_ready_a", {60'b0, req_ready_a}, 64'd0);
    check("rst_ready_b", {62'b0, req_ready_b}, 64'd0);
    check("rst_rsp_valid", {63'b0, rsp_valid_a}, 64'd0);
    check("rst_rsp_id", {62'b0, rsp_id_a}, 64'd0);
    check("rst_rsp_data", {16'b0, rsp_data_a}, 64'd0);
    check("rst_busy", {63'b0, busy_a}, 64'd0);
    check("rst_grant_cnt", {48'b0, grant_cnt_a}, 64'd0);
    tick();
    req_valid_a = '0; req_valid_b = '0;
    rst = 1'b0;

    // Requester 1, taps 1..8 in Q25.23.
    for (int k = 0; k < 8; k++) req_win_a[(8+k)*W +: W] = W'(k + 1) << 23;
    xfer_a(1, 1'b0, 48'h0000_0080_0000);
    xfer_a(1, 1'b1, 48'hFFFF_FC00_0000);

    // All four valid: rotation 0,1,2,3,0,1,2,3; results follow 3 cycles later.
    do_reset();
    req_win_a = '0; req_hi_a = '0;
    for (int i = 0; i < 4; i++) req_win_a[(i*8)*W +: W] = W'(i + 10) << 23;
    for (int c = 0; c < 12; c++) begin
      req_valid_a = (c < 8) ? 4'hF : 4'h0;
      @(negedge clk);
      if (c < 8) check("rr_ready", {60'b0, req_ready_a}, 64'(4'b0001 << (c % 4)));
      if (c == 3) check("rr_busy", {63'b0, busy_a}, 64'd1);
      check("rr_rsp_valid", {63'b0, rsp_valid_a}, (c >= 3 && c < 11) ? 64'd1 : 64'd0);
      if (c >= 3 && c < 11) begin
        check("rr_rsp_id", {62'b0, rsp_id_a}, 64'((c - 3) % 4));
        check("rr_rsp_data", {16'b0, rsp_data_a}, 64'((c - 3) % 4 + 10) << 23);
      end
      tick();
    end
    for (int i = 0; i < 4; i++) check("rr_grant_cnt", {60'b0, grant_cnt_a[i*4 +: 4]}, 64'd2);

    // Requester 2 masked off: 0,1,3,0,1,3.
    do_reset();
    req_mask_a = 4'b1011;
    req_valid_a = 4'hF;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("mask_ready", {60'b0, req_ready_a}, 64'(4'b0001 << seq_mask[c]));
      tick();
    end
    req_valid_a = '0;
    req_mask_a  = 4'hF;
    for (int c = 0; c < 4; c++) tick();

    // Reset one cycle after a grant discards the window.
    do_reset();
    req_valid_a = 4'b0001;
    @(negedge clk);
    check("flush_ready", {60'b0, req_ready_a}, 64'd1);
    tick();
    req_valid_a = '0;
    rst = 1'b1;
    @(negedge clk);
    check("flush_busy_pre", {63'b0, busy_a}, 64'd1);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("flush_busy_post", {63'b0, busy_a}, 64'd0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("flush_rsp_valid", {63'b0, rsp_valid_a}, 64'd0);
      tick();
    end

    // Single requester granted every cycle; counter saturates at 15.
    do_reset();
    req_valid_a = 4'b0001;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check("single_ready", {60'b0, req_ready_a}, 64'd1);
      tick();
    end
    req_valid_a = '0;
    @(negedge clk);
    check("sat_cnt0", {60'b0, grant_cnt_a[3:0]}, 64'd15);
    check("sat_cnt1", {60'b0, grant_cnt_a[7:4]}, 64'd0);
    tick();

    // Full-scale negative taps, coefficients just below 1.0: floor truncation.
    req_win_b[(8+0)*W +: W] = 48'h8000_0000_0001;
    req_win_b[(8+1)*W +: W] = 48'h8000_0000_0000;
    xfer_b(1'b0, 48'h8000_0100_0000);
    xfer_b(1'b1, 48'h8000_0400_0000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
